// File: rtl/lcd_capture.sv
// lcd_capture: sink for the PPU display interface.
// Rebuilds pixel coordinates from the sync strobes, packs 2-bit colours four
// per byte (first pixel of a group in [7:6]) and writes each completed byte
// to a row-major framebuffer, WIDTH/4 bytes per line.
//
// Ports:
//   clk, rst                  system clock (shared with the PPU), async active-high reset
//   lcd_hsync, lcd_vsync      high during horizontal / vertical blank
//   lcd_pixel, lcd_color      pixel-valid strobe and 2-bit colour
//   fb_addr, fb_d_wr          framebuffer byte address and packed data
//   fb_write                  one-cycle write strobe per completed byte
//   frame_done                pulse: complete, error-free frame written
//   err_line                  pulse: short line or pixel overflow
//   err_frame                 pulse: frame ended with a line count other than HEIGHT
module lcd_capture #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 144,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lcd_hsync,
  input  logic              lcd_vsync,
  input  logic              lcd_pixel,
  input  logic [1:0]        lcd_color,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_d_wr,
  output logic              fb_write,
  output logic              frame_done,
  output logic              err_line,
  output logic              err_frame
);

  localparam int XW = $clog2(WIDTH + 1);
  localparam logic [XW-1:0]     X_END     = XW'(WIDTH);
  localparam logic [7:0]        Y_END     = 8'(HEIGHT);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(WIDTH / 4);
  localparam logic [ADDR_W-1:0] LB_MAX    = {ADDR_W{1'b1}} - LINE_STEP;

  typedef enum logic [1:0] {SYNC, ACTIVE, VBLANK} state_t;

  state_t            state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [7:0]        y_q, y_d;
  logic [ADDR_W-1:0] line_base_q, line_base_d;
  logic [7:0]        pack_q, pack_d;
  logic              hsync_q, vsync_q;
  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [7:0]        fb_d_wr_q, fb_d_wr_d;
  logic              fb_write_q, fb_write_d;
  logic              frame_done_q, frame_done_d;
  logic              err_line_q, err_line_d;
  logic              err_frame_q, err_frame_d;

  logic hs_rise, vs_rise, vs_fall, pix_strobe, in_range;

  assign hs_rise    = lcd_hsync & ~hsync_q;
  assign vs_rise    = lcd_vsync & ~vsync_q;
  assign vs_fall    = ~lcd_vsync & vsync_q;
  assign pix_strobe = lcd_pixel & ~lcd_hsync & ~lcd_vsync;
  assign in_range   = (x_q < X_END) && (y_q < Y_END);

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    line_base_d  = line_base_q;
    pack_d       = pack_q;
    fb_addr_d    = fb_addr_q;
    fb_d_wr_d    = fb_d_wr_q;
    fb_write_d   = 1'b0;
    frame_done_d = 1'b0;
    err_line_d   = 1'b0;
    err_frame_d  = 1'b0;

    case (state_q)
      SYNC, VBLANK: begin
        if (vs_fall) begin
          x_d         = '0;
          y_d         = '0;
          line_base_d = '0;
          pack_d      = '0;
          state_d     = ACTIVE;
        end
      end
      ACTIVE: begin
        if (vs_rise) begin
          state_d = VBLANK;
          pack_d  = '0;
          if (y_q == Y_END) frame_done_d = 1'b1;
          else              err_frame_d  = 1'b1;
        end else if (hs_rise) begin
          if ((x_q != X_END) && (y_q < Y_END)) err_line_d = 1'b1;
          x_d    = '0;
          pack_d = '0;
          if (y_q != 8'hFF) y_d = y_q + 8'd1;
          // Saturating accumulator; rows past HEIGHT never write, so the
          // clamped value is never used as an address.
          line_base_d = (line_base_q > LB_MAX) ? '1 : line_base_q + LINE_STEP;
        end else if (pix_strobe) begin
          if (in_range) begin
            pack_d = {pack_q[5:0], lcd_color};
            x_d    = x_q + XW'(1);
            if (x_q[1:0] == 2'd3) begin
              fb_write_d = 1'b1;
              fb_d_wr_d  = pack_d;
              fb_addr_d  = line_base_q + ADDR_W'(x_q >> 2);
            end
          end else begin
            err_line_d = 1'b1;
          end
        end
      end
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= SYNC;
      x_q          <= '0;
      y_q          <= '0;
      line_base_q  <= '0;
      pack_q       <= '0;
      hsync_q      <= 1'b0;
      vsync_q      <= 1'b0;
      fb_addr_q    <= '0;
      fb_d_wr_q    <= '0;
      fb_write_q   <= 1'b0;
      frame_done_q <= 1'b0;
      err_line_q   <= 1'b0;
      err_frame_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      line_base_q  <= line_base_d;
      pack_q       <= pack_d;
      hsync_q      <= lcd_hsync;
      vsync_q      <= lcd_vsync;
      fb_addr_q    <= fb_addr_d;
      fb_d_wr_q    <= fb_d_wr_d;
      fb_write_q   <= fb_write_d;
      frame_done_q <= frame_done_d;
      err_line_q   <= err_line_d;
      err_frame_q  <= err_frame_d;
    end
  end

  assign fb_addr    = fb_addr_q;
  assign fb_d_wr    = fb_d_wr_q;
  assign fb_write   = fb_write_q;
  assign frame_done = frame_done_q;
  assign err_line   = err_line_q;
  assign err_frame  = err_frame_q;

endmodule

// File: tb/tb_lcd_capture.sv
// Bench for lcd_capture: a coordinate/queue model predicts every output each
// cycle; scenario-level literal counts pin the model.
module tb_lcd_capture;
  localparam int WIDTH  = 160;
  localparam int HEIGHT = 144;
  localparam int ADDR_W = 13;

  logic              clk = 1'b0;
  logic              rst;
  logic              lcd_hsync, lcd_vsync, lcd_pixel;
  logic [1:0]        lcd_color;
  logic [ADDR_W-1:0] fb_addr;
  logic [7:0]        fb_d_wr;
  logic              fb_write, frame_done, err_line, err_frame;

  lcd_capture #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync),
    .lcd_pixel(lcd_pixel), .lcd_color(lcd_color),
    .fb_addr(fb_addr), .fb_d_wr(fb_d_wr), .fb_write(fb_write),
    .frame_done(frame_done), .err_line(err_line), .err_frame(err_frame)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Observed DUT activity
  int         n_wr = 0, n_fd = 0, n_el = 0, n_ef = 0;
  logic [7:0] fb_mem  [0:(1<<ADDR_W)-1];
  bit         written [0:(1<<ADDR_W)-1];

  // Reference model: capture mode, pixel coordinates, current colour group
  int         m_mode;   // 0 = waiting for first vsync fall, 1 = capturing, 2 = blank
  int         mx, my;
  logic [1:0] grp[$];
  logic       m_hs, m_vs;
  bit         e_wr, e_fd, e_el, e_ef;
  int         e_addr;
  logic [7:0] e_data;

  always @(posedge clk) begin
    bit hr, vr, vf;
    if (rst) begin
      m_mode = 0; mx = 0; my = 0; grp.delete();
      m_hs = 1'b0; m_vs = 1'b0;
      e_wr = 0; e_fd = 0; e_el = 0; e_ef = 0; e_addr = 0; e_data = 8'h00;
    end else begin
      hr = lcd_hsync && !m_hs;
      vr = lcd_vsync && !m_vs;
      vf = !lcd_vsync && m_vs;
      e_wr = 0; e_fd = 0; e_el = 0; e_ef = 0;
      if (m_mode != 1) begin
        if (vf) begin m_mode = 1; mx = 0; my = 0; grp.delete(); end
      end else if (vr) begin
        m_mode = 2;
        grp.delete();
        if (my == HEIGHT) e_fd = 1; else e_ef = 1;
      end else if (hr) begin
        if (mx != WIDTH && my < HEIGHT) e_el = 1;
        mx = 0;
        grp.delete();
        if (my < 255) my++;
      end else if (lcd_pixel && !lcd_hsync && !lcd_vsync) begin
        if (mx < WIDTH && my < HEIGHT) begin
          grp.push_back(lcd_color);
          if (grp.size() == 4) begin
            e_wr   = 1;
            e_data = {grp[0], grp[1], grp[2], grp[3]};
            e_addr = my * (WIDTH / 4) + mx / 4;
            grp.delete();
          end
          mx++;
        end else begin
          e_el = 1;
        end
      end
      m_hs = lcd_hsync;
      m_vs = lcd_vsync;
    end
    #1;
    chk("fb_write", {31'd0, fb_write}, {31'd0, e_wr});
    chk("frame_done", {31'd0, frame_done}, {31'd0, e_fd});
    chk("err_line", {31'd0, err_line}, {31'd0, e_el});
    chk("err_frame", {31'd0, err_frame}, {31'd0, e_ef});
    if (e_wr || rst) begin
      chk("fb_addr", 32'(fb_addr), e_addr);
      chk("fb_d_wr", 32'(fb_d_wr), 32'(e_data));
    end
    if (fb_write === 1'b1) begin
      n_wr++;
      if (!$isunknown(fb_addr)) begin
        fb_mem[fb_addr]  = fb_d_wr;
        written[fb_addr] = 1'b1;
      end
    end
    if (frame_done === 1'b1) n_fd++;
    if (err_line   === 1'b1) n_el++;
    if (err_frame  === 1'b1) n_ef++;
  end

  // Stimulus
  int s_wr, s_fd, s_el, s_ef;

  task automatic snap();
    s_wr = n_wr; s_fd = n_fd; s_el = n_el; s_ef = n_ef;
  endtask

  task automatic clear_mem();
    for (int unsigned a = 0; a < (1 << ADDR_W); a++) begin
      fb_mem[a] = 8'h00; written[a] = 1'b0;
    end
  endtask

  task automatic step(input logic h, input logic v, input logic p, input logic [1:0] c);
    lcd_hsync = h; lcd_vsync = v; lcd_pixel = p; lcd_color = c;
    @(negedge clk);
  endtask

  task automatic frame_start();
    repeat (3) step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    repeat (2) step(1'b0, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic frame_end();
    repeat (4) step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
  endtask

  // mode 0: colour = x[1:0]; mode 1: random colours with idle gaps; mode 2: 3,2,1,0 then 0
  task automatic line(input int n, input int mode);
    logic [1:0] c;
    for (int i = 0; i < n; i++) begin
      if (mode == 1 && $urandom_range(0, 7) == 0)
        step(1'b0, 1'b0, 1'b0, 2'($urandom_range(0, 3)));
      case (mode)
        0:       c = 2'(i);
        1:       c = 2'($urandom_range(0, 3));
        default: c = (i < 4) ? 2'(3 - i) : 2'd0;
      endcase
      step(1'b0, 1'b0, 1'b1, c);
    end
    repeat (2) step(1'b1, 1'b0, (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0, 2'($urandom_range(0, 3)));
    step(1'b0, 1'b0, 1'b0, 2'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    int bad;
    rst = 1'b1;
    lcd_hsync = 1'b0; lcd_vsync = 1'b0; lcd_pixel = 1'b0; lcd_color = 2'd0;
    clear_mem();
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({fb_write, frame_done, err_line, err_frame, fb_addr, fb_d_wr}), 32'd0);
    rst = 1'b0;

    // Pixels and hsync before any vsync fall: nothing written
    snap();
    for (int k = 0; k < 3; k++) line(20, 1);
    chk("pre_vsync_writes", n_wr - s_wr, 0);
    chk("pre_vsync_err_line", n_el - s_el, 0);

    // Short frame: patterned line 0, short line 5, overlong line 7, ends at y=8
    clear_mem(); snap();
    frame_start();
    line(160, 2);
    for (int k = 0; k < 4; k++) line(160, 0);
    line(158, 0);
    line(160, 0);
    line(161, 0);
    frame_end();
    chk("short_frame_writes", n_wr - s_wr, 319);
    chk("short_frame_err_line", n_el - s_el, 2);
    chk("short_frame_err_frame", n_ef - s_ef, 1);
    chk("short_frame_done", n_fd - s_fd, 0);
    chk("first_byte", 32'(fb_mem[0]), 32'h0000_00E4);
    chk("second_byte", 32'(fb_mem[1]), 32'h0);
    chk("short_line_last_unwritten", 32'(written[239]), 32'd0);
    chk("line6_start_written", 32'(written[240]), 32'd1);
    chk("line6_start_data", 32'(fb_mem[240]), 32'h0000_001B);

    // Full conforming frame, colour = x[1:0]
    clear_mem(); snap();
    frame_start();
    for (int k = 0; k < HEIGHT; k++) line(WIDTH, 0);
    frame_end();
    chk("frameA_writes", n_wr - s_wr, 5760);
    chk("frameA_done", n_fd - s_fd, 1);
    chk("frameA_err_line", n_el - s_el, 0);
    chk("frameA_err_frame", n_ef - s_ef, 0);
    bad = 0;
    for (int a = 0; a < 5760; a++) if (!written[a] || fb_mem[a] !== 8'h1B) bad++;
    chk("frameA_contents", bad, 0);
    chk("frameA_no_write_past_end", 32'(written[5760]), 32'd0);

    // Frame cut short at 100 lines, then a clean random frame
    snap();
    frame_start();
    for (int k = 0; k < 100; k++) line(WIDTH, 0);
    frame_end();
    chk("frame100_err_frame", n_ef - s_ef, 1);
    chk("frame100_done", n_fd - s_fd, 0);
    chk("frame100_writes", n_wr - s_wr, 4000);

    snap();
    frame_start();
    for (int k = 0; k < HEIGHT; k++) line(WIDTH, 1);
    frame_end();
    chk("frameB_done", n_fd - s_fd, 1);
    chk("frameB_err_frame", n_ef - s_ef, 0);
    chk("frameB_err_line", n_el - s_el, 0);
    chk("frameB_writes", n_wr - s_wr, 5760);

    // Reset asserted mid-line at x=50
    frame_start();
    for (int i = 0; i < 50; i++) step(1'b0, 1'b0, 1'b1, 2'(i));
    lcd_pixel = 1'b0;
    rst = 1'b1;
    #1;
    chk("midline_reset_outputs", 32'({fb_write, frame_done, err_line, err_frame, fb_addr, fb_d_wr}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_mem(); snap();
    line(20, 0);
    chk("after_reset_writes", n_wr - s_wr, 0);
    frame_start();
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 2'(i));
    repeat (2) step(1'b0, 1'b0, 1'b0, 2'd0);
    chk("after_vsync_writes", n_wr - s_wr, 2);
    chk("after_vsync_data", 32'(fb_mem[0]), 32'h0000_001B);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
